// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
//   Sequencer between the EX stage and an iterative divider core. It latches
//   the DIV/DIVU operands, drives the core, stalls EX while a divide is in
//   flight, and holds the {hi,lo} result until the instruction leaves EX.
//   Divide-by-zero is resolved locally. A watchdog aborts a core that never
//   answers, so EX itself can stay purely combinational.
//
// Ports
//   clk, resetn            clock (rising edge), async active-low reset
//   flush                  pipeline flush, kills any in-flight divide
//   hold_i                 EX held by a later stage (instruction stays in EX)
//   div_req_i              EX holds a DIV/DIVU (level)
//   div_signed_i           1 = DIV, 0 = DIVU
//   div_op1_i, div_op2_i   dividend / divisor
//   stallreq_o             stall request to the pipeline stall controller
//   result_valid_o         result_o is final for the current instruction
//   result_o               {remainder, quotient}, registered
//   timeout_o              one-cycle pulse when the watchdog aborts
//   core_start_o           divider core run/keep-running
//   core_annul_o           divider core abort, one-cycle pulse
//   core_signed_o          latched signed flag
//   core_op1_o, core_op2_o latched operands
//   core_result_i          core result {hi,lo}
//   core_ready_i           core result valid, single-cycle pulse
module div_seq_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            hold_i,
    input  logic            div_req_i,
    input  logic            div_signed_i,
    input  logic [DW-1:0]   div_op1_i,
    input  logic [DW-1:0]   div_op2_i,
    output logic            stallreq_o,
    output logic            result_valid_o,
    output logic [2*DW-1:0] result_o,
    output logic            timeout_o,
    output logic            core_start_o,
    output logic            core_annul_o,
    output logic            core_signed_o,
    output logic [DW-1:0]   core_op1_o,
    output logic [DW-1:0]   core_op2_o,
    input  logic [2*DW-1:0] core_result_i,
    input  logic            core_ready_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DZERO, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             valid_q;
    logic             is_busy;
    logic             wd_hit;

    assign is_busy = (state == BUSY);
    // Last BUSY cycle the watchdog allows before aborting.
    assign wd_hit  = (cnt == CNT_W'(TIMEOUT - 1));

    // Start, annul and timeout must act in the same cycle as the condition
    // (flush or watchdog expiry), so they are decoded from the registered
    // state rather than registered themselves.
    assign core_start_o = is_busy;
    assign core_annul_o = is_busy & (flush | (wd_hit & ~core_ready_i));
    assign timeout_o    = is_busy & ~flush & wd_hit & ~core_ready_i;

    // A flush kills the instruction, so its result is no longer valid even
    // in the flush cycle itself.
    assign result_valid_o = valid_q & ~flush;

    always_comb begin
        stallreq_o = 1'b0;
        case (state)
            IDLE:    stallreq_o = div_req_i;
            BUSY:    stallreq_o = 1'b1;
            DZERO:   stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
        if (flush) stallreq_o = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            valid_q       <= 1'b0;
            result_o      <= '0;
            core_signed_o <= 1'b0;
            core_op1_o    <= '0;
            core_op2_o    <= '0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_req_i) begin
                        core_signed_o <= div_signed_i;
                        core_op1_o    <= div_op1_i;
                        core_op2_o    <= div_op2_i;
                        cnt           <= '0;
                        state         <= (div_op2_i == '0) ? DZERO : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (core_ready_i) begin
                        result_o <= core_result_i;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end else if (wd_hit) begin
                        // Abort with a zero result so the pipeline never deadlocks.
                        result_o <= '0;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DZERO: begin
                    // Divide-by-zero: remainder = dividend, quotient = all ones.
                    result_o <= {core_op1_o, {DW{1'b1}}};
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // Leave only when the instruction advances; a div_req_i
                    // still high here belongs to the same instruction.
                    if (!hold_i) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a small behavioural divider-core stub
// that pulses core_ready_i after a chosen number of core_start_o cycles.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush, hold_i, div_req_i, div_signed_i;
    logic [31:0] div_op1_i, div_op2_i;
    logic        stallreq_o, result_valid_o, timeout_o;
    logic [63:0] result_o;
    logic        core_start_o, core_annul_o, core_signed_o;
    logic [31:0] core_op1_o, core_op2_o;
    logic [63:0] core_result_i;
    logic        core_ready_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.DW(32), .TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .hold_i(hold_i),
        .div_req_i(div_req_i), .div_signed_i(div_signed_i),
        .div_op1_i(div_op1_i), .div_op2_i(div_op2_i),
        .stallreq_o(stallreq_o), .result_valid_o(result_valid_o),
        .result_o(result_o), .timeout_o(timeout_o),
        .core_start_o(core_start_o), .core_annul_o(core_annul_o),
        .core_signed_o(core_signed_o), .core_op1_o(core_op1_o),
        .core_op2_o(core_op2_o), .core_result_i(core_result_i),
        .core_ready_i(core_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue a divide and run until result_valid_o (bounded). Inputs change on
    // the falling edge; outputs are sampled #1 later in the same cycle.
    // Returns with div_req_i still high, in the first DONE cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int ready_at, input logic [63:0] core_res,
                           output int stalls, output int starts, output int lat,
                           output int annuls, output int to_cyc);
        stalls = 0; starts = 0; lat = -1; annuls = 0; to_cyc = -1;
        div_req_i = 1'b1; div_signed_i = s; div_op1_i = a; div_op2_i = b;
        core_result_i = core_res;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (core_start_o) begin
                starts++;
                core_ready_i = (starts == ready_at);
                if (starts == 1) begin
                    chk("core_op1", {32'd0, core_op1_o}, {32'd0, a});
                    chk("core_op2", {32'd0, core_op2_o}, {32'd0, b});
                    chk("core_signed", {63'd0, core_signed_o}, {63'd0, s});
                end
            end else begin
                core_ready_i = 1'b0;
            end
            #1;
            if (stallreq_o) stalls++;
            if (core_annul_o) annuls++;
            if (timeout_o) to_cyc = c;
            if (result_valid_o) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        core_ready_i = 1'b0;
        if (lat < 0) chk("run_div_bound", 64'd1, 64'd0);
    endtask

    // Instruction advances (hold_i low in the DONE cycle): next cycle is IDLE.
    task automatic leave_done(input string tag);
        @(negedge clk);
        div_req_i = 1'b0;
        #1;
        chk({tag, "_valid_1cyc"}, {63'd0, result_valid_o}, 64'd0);
        chk({tag, "_idle_stall"}, {63'd0, stallreq_o}, 64'd0);
    endtask

    initial begin
        int stalls, starts, lat, annuls, to_cyc;
        resetn = 1'b0; flush = 1'b0; hold_i = 1'b0; div_req_i = 1'b0;
        div_signed_i = 1'b0; div_op1_i = '0; div_op2_i = '0;
        core_result_i = '0; core_ready_i = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_result", result_o, 64'd0);
        chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
        chk("rst_start", {63'd0, core_start_o}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // DIVU 100/7, core ready on its 33rd busy cycle
        run_div(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, stalls, starts, lat, annuls, to_cyc);
        chk("divu_stalls", 64'(stalls), 64'd34);
        chk("divu_latency", 64'(lat), 64'd34);
        chk("divu_result", result_o, {32'd2, 32'd14});
        chk("divu_no_annul", 64'(annuls), 64'd0);
        leave_done("divu");

        // DIV -7/2 signed
        @(negedge clk);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                stalls, starts, lat, annuls, to_cyc);
        chk("div_signed_result", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("div_signed_latency", 64'(lat), 64'd6);
        leave_done("div_signed");

        // DIV 5/0: no core start, result two cycles after the request
        @(negedge clk);
        run_div(32'd5, 32'd0, 1'b1, 1, 64'hDEAD_BEEF_DEAD_BEEF, stalls, starts, lat, annuls, to_cyc);
        chk("dz_starts", 64'(starts), 64'd0);
        chk("dz_latency", 64'(lat), 64'd2);
        chk("dz_result", result_o, {32'd5, 32'hFFFF_FFFF});
        chk("dz_stalls", 64'(stalls), 64'd2);
        leave_done("dz");

        // Flush on the 10th busy cycle
        @(negedge clk);
        div_req_i = 1'b1; div_signed_i = 1'b0; div_op1_i = 32'd50; div_op2_i = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) begin
                #1;
                chk("fl_pre_annul", {63'd0, core_annul_o}, 64'd0);
                chk("fl_pre_stall", {63'd0, stallreq_o}, 64'd1);
            end
        end
        flush = 1'b1;
        #1;
        chk("fl_annul", {63'd0, core_annul_o}, 64'd1);
        chk("fl_stall", {63'd0, stallreq_o}, 64'd0);
        chk("fl_timeout", {63'd0, timeout_o}, 64'd0);
        @(negedge clk);
        flush = 1'b0; div_req_i = 1'b0;
        #1;
        chk("fl_idle_start", {63'd0, core_start_o}, 64'd0);
        chk("fl_annul_1cyc", {63'd0, core_annul_o}, 64'd0);
        chk("fl_idle_valid", {63'd0, result_valid_o}, 64'd0);

        // Hold in DONE for 5 cycles with div_req_i still high
        @(negedge clk);
        hold_i = 1'b1;
        run_div(32'd9, 32'd2, 1'b0, 3, {32'd1, 32'd4}, stalls, starts, lat, annuls, to_cyc);
        chk("hold_result", result_o, {32'd1, 32'd4});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", {63'd0, result_valid_o}, 64'd1);
            chk("hold_stable", result_o, {32'd1, 32'd4});
            chk("hold_no_restart", {63'd0, core_start_o}, 64'd0);
            chk("hold_stall", {63'd0, stallreq_o}, 64'd0);
        end
        @(negedge clk);
        hold_i = 1'b0;
        #1;
        chk("hold_release_valid", {63'd0, result_valid_o}, 64'd1);
        leave_done("hold");
        chk("hold_idle_start", {63'd0, core_start_o}, 64'd0);

        // Async reset in the middle of a busy divide
        @(negedge clk);
        div_req_i = 1'b1; div_signed_i = 1'b1; div_op1_i = 32'd20; div_op2_i = 32'd6;
        for (int c = 0; c < 5; c++) @(negedge clk);
        #1;
        chk("mid_busy_start", {63'd0, core_start_o}, 64'd1);
        resetn = 1'b0; div_req_i = 1'b0;
        #1;
        chk("mrst_result", result_o, 64'd0);
        chk("mrst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("mrst_start", {63'd0, core_start_o}, 64'd0);
        chk("mrst_annul", {63'd0, core_annul_o}, 64'd0);
        chk("mrst_ops", {core_op1_o, core_op2_o}, 64'd0);
        chk("mrst_signed", {63'd0, core_signed_o}, 64'd0);
        chk("mrst_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Core never ready: watchdog aborts on the 40th busy cycle
        run_div(32'd77, 32'd5, 1'b0, 1000, 64'hFFFF_0000_FFFF_0000, stalls, starts, lat, annuls, to_cyc);
        chk("wd_timeout_cyc", 64'(to_cyc), 64'd40);
        chk("wd_annuls", 64'(annuls), 64'd1);
        chk("wd_starts", 64'(starts), 64'd40);
        chk("wd_latency", 64'(lat), 64'd41);
        chk("wd_result", result_o, 64'd0);
        chk("wd_timeout_1cyc", {63'd0, timeout_o}, 64'd0);
        leave_done("wd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
